fc_dot16_consumer: RTL

//  Weight-side consumer for the FC weight loader. It requests the 16 FC weights over the

---
 rtl/fc_dot16_consumer_pkg.sv | 20 ++
 rtl/fc_dot16_consumer_mac_sat.sv | 40 ++++
 rtl/fc_dot16_consumer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fc_dot16_consumer_pkg.sv
// Shared constants and FSM encoding for the 16-input FC dot-product consumer.
package fc_dot16_consumer_pkg;

    localparam int N_IN  = 16;   // inputs per vector, one per weight port
    localparam int FRAC  = 16;   // Q16.16 fractional bits
    localparam int ACC_W = 68;   // 64-bit product plus 4 guard bits for 16 terms
    localparam int IDX_W = 4;

    localparam logic [31:0] Q_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_MIN = 32'h8000_0000;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/fc_dot16_consumer_mac_sat.sv
// Combinational datapath: one signed MAC step and the Q16.16 shift/saturate.
module fc_dot16_consumer_mac_sat
    import fc_dot16_consumer_pkg::*;
(
    input  logic [ACC_W-1:0] acc_i,
    input  logic [31:0]      x_i,
    input  logic [31:0]      w_i,
    output logic [ACC_W-1:0] acc_o,
    input  logic [ACC_W-1:0] sacc_i,
    output logic [31:0]      y_o,
    output logic             sat_o
);

    logic signed [63:0]      xe;
    logic signed [63:0]      we;
    logic signed [63:0]      prod;
    logic signed [ACC_W-1:0] sh;
    logic                    hi;
    logic                    lo;

    // Full-precision signed product, sign-extended into the guarded accumulator.
    always_comb begin
        xe    = {{32{x_i[31]}}, x_i};
        we    = {{32{w_i[31]}}, w_i};
        prod  = xe * we;
        acc_o = acc_i + {{(ACC_W-64){prod[63]}}, prod};
    end

    // Arithmetic shift drops the fraction (floor), then clip to the 32-bit range.
    always_comb begin
        sh    = $signed(sacc_i) >>> FRAC;
        hi    = ~sh[ACC_W-1] & (|sh[ACC_W-2:31]);
        lo    = sh[ACC_W-1] & ~(&sh[ACC_W-2:31]);
        sat_o = hi | lo;
        if (hi)      y_o = Q_MAX;
        else if (lo) y_o = Q_MIN;
        else         y_o = sh[31:0];
    end

endmodule

// File: rtl/fc_dot16_consumer.sv
// FC weight consumer: loads 16 weights, then MACs 16 activations per vector
// and emits one saturated Q16.16 result on a valid/ready port.
module fc_dot16_consumer
    import fc_dot16_consumer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic        wl_load,
    input  logic        wl_load_done,
    input  logic [31:0] wl_w_0,
    input  logic [31:0] wl_w_1,
    input  logic [31:0] wl_w_2,
    input  logic [31:0] wl_w_3,
    input  logic [31:0] wl_w_4,
    input  logic [31:0] wl_w_5,
    input  logic [31:0] wl_w_6,
    input  logic [31:0] wl_w_7,
    input  logic [31:0] wl_w_8,
    input  logic [31:0] wl_w_9,
    input  logic [31:0] wl_w_10,
    input  logic [31:0] wl_w_11,
    input  logic [31:0] wl_w_12,
    input  logic [31:0] wl_w_13,
    input  logic [31:0] wl_w_14,
    input  logic [31:0] wl_w_15,
    input  logic        reload,
    output logic        weights_ready,
    input  logic        x_valid,
    output logic        x_ready,
    input  logic [31:0] x_data,
    output logic        y_valid,
    input  logic        y_ready,
    output logic [31:0] y_data,
    output logic        y_sat
);

    state_t             state_q;
    logic               wl_load_q;
    logic               wr_q;
    logic [31:0]        w_q [N_IN];
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [IDX_W-1:0]   idx_q;
    logic               yv_q;
    logic [31:0]        yd_q;
    logic               ys_q;
    logic [31:0]        y_d;
    logic               sat_d;
    logic [31:0]        wl_w [N_IN];
    logic               reload_go;
    logic               accept;

    assign wl_w[0]  = wl_w_0;
    assign wl_w[1]  = wl_w_1;
    assign wl_w[2]  = wl_w_2;
    assign wl_w[3]  = wl_w_3;
    assign wl_w[4]  = wl_w_4;
    assign wl_w[5]  = wl_w_5;
    assign wl_w[6]  = wl_w_6;
    assign wl_w[7]  = wl_w_7;
    assign wl_w[8]  = wl_w_8;
    assign wl_w[9]  = wl_w_9;
    assign wl_w[10] = wl_w_10;
    assign wl_w[11] = wl_w_11;
    assign wl_w[12] = wl_w_12;
    assign wl_w[13] = wl_w_13;
    assign wl_w[14] = wl_w_14;
    assign wl_w[15] = wl_w_15;

    // Reload only takes effect at a vector boundary; it steals the cycle from x.
    assign reload_go = (state_q == S_ACC) && reload && (idx_q == '0);
    assign x_ready   = (state_q == S_ACC) && !reload_go;
    assign accept    = x_valid && x_ready;

    assign wl_load       = wl_load_q;
    assign weights_ready = wr_q;
    assign y_valid       = yv_q;
    assign y_data        = yd_q;
    assign y_sat         = ys_q;

    fc_dot16_consumer_mac_sat u_mac (
        .acc_i  (acc_q),
        .x_i    (x_data),
        .w_i    (w_q[idx_q]),
        .acc_o  (acc_d),
        .sacc_i (acc_d),
        .y_o    (y_d),
        .sat_o  (sat_d)
    );

    // Control FSM with weight file, accumulator, index and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_LOAD;
            wl_load_q <= 1'b0;
            wr_q      <= 1'b0;
            acc_q     <= '0;
            idx_q     <= '0;
            yv_q      <= 1'b0;
            yd_q      <= '0;
            ys_q      <= 1'b0;
            for (int i = 0; i < N_IN; i++) w_q[i] <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    // A done already present on entry is taken without raising load.
                    if (wl_load_done) begin
                        for (int i = 0; i < N_IN; i++) w_q[i] <= wl_w[i];
                        wl_load_q <= 1'b0;
                        wr_q      <= 1'b1;
                        state_q   <= S_ACC;
                    end else begin
                        wl_load_q <= 1'b1;
                    end
                end
                S_ACC: begin
                    if (reload_go) begin
                        wr_q    <= 1'b0;
                        state_q <= S_LOAD;
                    end else if (accept) begin
                        acc_q <= acc_d;
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            state_q <= S_OUT;
                            yv_q    <= 1'b1;
                            yd_q    <= y_d;
                            ys_q    <= sat_d;
                        end
                    end
                end
                S_OUT: begin
                    if (y_ready) begin
                        yv_q    <= 1'b0;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        state_q <= S_ACC;
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

endmodule
